mfsr_seq: RTL and testbench

Parametrised multi-function shift engine: a WIDTH-bit register with the eight-mode shift/rotate set, extended with multi-step operations. A single start command performs `amt` single-bit steps in sequence, with busy/done handshaking, a stall input and a serial-out bit. It is the generalised successor to the fixed 4-bit multi-function shift register in the digital-circuits experiment set. It is intended for serial/parallel conversion and shift-based arithmetic experiments.

---
 rtl/mfsr_seq.sv | 152 +++++++++++++++
 tb/tb_mfsr_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mfsr_seq.sv
// mfsr_seq -- multi-step, multi-function shift engine.
//
// A WIDTH-bit register supporting clear, load and six single-bit shift/rotate
// modes. One start command runs the selected shift mode for `amt` steps, one
// step per enabled clock, reporting busy while running and a one-cycle done
// pulse at completion. All state changes on the falling edge of clk.
//
// Build option: define MFSR_SOUT_EN to implement the serial-out register;
// without it sout is tied low.
//
// Ports:
//   clk    clock (falling-edge active)
//   rst    synchronous active-high reset
//   start  command strobe, accepted only when idle
//   sel    mode: 000 clear, 001 load, 010 lsr, 011 lsl, 100 asr,
//          101 right with inp into MSB, 110 ror, 111 rol
//   amt    step count for shift modes (0 completes immediately)
//   d      parallel load data
//   inp    serial input for mode 101
//   en     step enable; low stalls a running operation
//   q      register contents
//   sout   bit shifted out on the most recent step
//   busy   high while a multi-step operation is running
//   done   one-cycle completion pulse
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | waiting for start; clear/load/amt=0 finish here
// S_SHIFT | executing steps of the latched mode, count > 0
module mfsr_seq #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       sel,
  input  logic [CW-1:0]    amt,
  input  logic [WIDTH-1:0] d,
  input  logic             inp,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [2:0] M_CLR  = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_SHL  = 3'b011;
  localparam logic [2:0] M_ASR  = 3'b100;
  localparam logic [2:0] M_SIN  = 3'b101;
  localparam logic [2:0] M_ROR  = 3'b110;
  localparam logic [2:0] M_ROL  = 3'b111;

  logic [0:0]       state;
  logic [2:0]       mode;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_step;
  logic             step_en;
  logic             last_step;
  logic             cmd_imm;

  always_comb begin
    q_step = q;
    case (mode)
      M_SHR:   q_step = {1'b0, q[WIDTH-1:1]};
      M_SHL:   q_step = {q[WIDTH-2:0], 1'b0};
      M_ASR:   q_step = {q[WIDTH-1], q[WIDTH-1:1]};
      M_SIN:   q_step = {inp, q[WIDTH-1:1]};
      M_ROR:   q_step = {q[0], q[WIDTH-1:1]};
      M_ROL:   q_step = {q[WIDTH-2:0], q[WIDTH-1]};
      default: q_step = q;
    endcase
  end

  assign step_en   = (state == S_SHIFT) && en;
  // count is a down-counter; the step taken while it reads 1 is the last.
  assign last_step = step_en && (count == CW'(1));
  // clear/load complete in the accepting cycle
  assign cmd_imm   = (state == S_IDLE) && start && (sel[2:1] == 2'b00);
  assign busy      = (state == S_SHIFT);

  always_ff @(negedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      mode  <= M_CLR;
      count <= '0;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (sel == M_CLR) begin
              q    <= '0;
              done <= 1'b1;
            end else if (sel == M_LOAD) begin
              q    <= d;
              done <= 1'b1;
            end else if (amt == '0) begin
              done <= 1'b1;
            end else begin
              mode  <= sel;
              count <= amt;
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (step_en) begin
            q     <= q_step;
            count <= count - CW'(1);
            if (last_step) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MFSR_SOUT_EN
  logic bit_out;
  logic sout_r;

  assign bit_out = ((mode == M_SHL) || (mode == M_ROL)) ? q[WIDTH-1] : q[0];

  always_ff @(negedge clk) begin
    if (rst)
      sout_r <= 1'b0;
    else if (cmd_imm)
      sout_r <= 1'b0;
    else if (step_en)
      sout_r <= bit_out;
  end

  assign sout = sout_r;
`else
  logic unused_cmd_imm;
  assign unused_cmd_imm = cmd_imm;
  assign sout = 1'b0;
`endif

endmodule

// File: tb/tb_mfsr_seq.sv
module tb_mfsr_seq;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH) + 1;
`ifdef MFSR_SOUT_EN
  localparam bit SOUT_EN = 1'b1;
`else
  localparam bit SOUT_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic [2:0]       sel;
  logic [CW-1:0]    amt;
  logic [WIDTH-1:0] d;
  logic             inp;
  logic             en;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  mfsr_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .amt(amt), .d(d),
    .inp(inp), .en(en), .q(q), .sout(sout), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] init;
    logic [2:0] sel;
    logic [3:0] amt;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic       exp_s;
    int         lat;
  } vec_t;

  vec_t       vecs[13];
  logic [7:0] sb[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // outputs change on negedge; sample and drive just after posedge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] s, input logic [3:0] a, input logic [7:0] dd,
                       input logic [7:0] eq, input bit push);
    start = 1'b1; sel = s; amt = a; d = dd;
    if (push) sb.push_back(eq);
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 64) begin
      cyc();
      n++;
    end
    if (!done) chk("done_wait", {31'd0, done}, 32'd1);
  endtask

  // scoreboard: every done pops the expected final value of q
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_q", {24'd0, q}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int busy_cnt;
    int done_cnt;

    //          init   sel     amt   d      exp_q  sout lat
    vecs[0]  = '{8'h00, 3'b001, 4'd0, 8'hB4, 8'hB4, 1'b0, 1};
    vecs[1]  = '{8'h5A, 3'b000, 4'd5, 8'hFF, 8'h00, 1'b0, 1};
    vecs[2]  = '{8'h96, 3'b100, 4'd3, 8'h00, 8'hF2, 1'b1, 4};
    vecs[3]  = '{8'h81, 3'b111, 4'd9, 8'h00, 8'h03, 1'b1, 10};
    vecs[4]  = '{8'hF0, 3'b010, 4'd2, 8'h00, 8'h3C, 1'b0, 3};
    vecs[5]  = '{8'h81, 3'b011, 4'd1, 8'h00, 8'h02, 1'b1, 2};
    vecs[6]  = '{8'hFF, 3'b010, 4'd8, 8'h00, 8'h00, 1'b1, 9};
    vecs[7]  = '{8'hA5, 3'b011, 4'd15, 8'h00, 8'h00, 1'b0, 16};
    vecs[8]  = '{8'h01, 3'b110, 4'd1, 8'h00, 8'h80, 1'b1, 2};
    vecs[9]  = '{8'h3C, 3'b110, 4'd4, 8'h00, 8'hC3, 1'b1, 5};
    vecs[10] = '{8'h77, 3'b010, 4'd0, 8'h00, 8'h77, 1'b0, 1};
    vecs[11] = '{8'h40, 3'b100, 4'd2, 8'h00, 8'h10, 1'b0, 3};
    vecs[12] = '{8'hFF, 3'b101, 4'd3, 8'h00, 8'h1F, 1'b1, 4};

    rst = 1'b1; start = 1'b0; sel = 3'b000; amt = '0; d = '0; inp = 1'b0; en = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_q", {24'd0, q}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sout", {31'd0, sout}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      issue(3'b001, 4'd0, vecs[i].init, vecs[i].init, 1'b1);
      wait_done(n);
      issue(vecs[i].sel, vecs[i].amt, vecs[i].d, vecs[i].exp_q, 1'b1);
      wait_done(n);
      chk($sformatf("vec%0d_q", i), {24'd0, q}, {24'd0, vecs[i].exp_q});
      chk($sformatf("vec%0d_sout", i), {31'd0, sout}, {31'd0, vecs[i].exp_s & SOUT_EN});
      chk($sformatf("vec%0d_lat", i), n, vecs[i].lat);
    end

    // stall with serial input: steps at E1,E2,E5,E6
    cyc();
    issue(3'b001, 4'd0, 8'h00, 8'h00, 1'b1);
    wait_done(n);
    issue(3'b101, 4'd4, 8'h00, 8'hD0, 1'b1);
    busy_cnt = busy ? 1 : 0;
    en = 1'b1; inp = 1'b1;
    cyc(); if (busy) busy_cnt++;
    inp = 1'b0;
    cyc(); if (busy) busy_cnt++;
    chk("stall_q_e2", {24'd0, q}, 32'h40);
    en = 1'b0; inp = 1'b1;
    cyc(); if (busy) busy_cnt++;
    cyc(); if (busy) busy_cnt++;
    chk("stall_q_hold", {24'd0, q}, 32'h40);
    chk("stall_busy_hold", {31'd0, busy}, 32'd1);
    en = 1'b1;
    cyc(); if (busy) busy_cnt++;
    chk("stall_q_e5", {24'd0, q}, 32'hA0);
    cyc(); if (busy) busy_cnt++;
    chk("stall_done", {31'd0, done}, 32'd1);
    chk("stall_q", {24'd0, q}, 32'hD0);
    chk("stall_busy_cycles", busy_cnt, 6);
    inp = 1'b0;

    // start while busy is ignored
    cyc();
    issue(3'b001, 4'd0, 8'h96, 8'h96, 1'b1);
    wait_done(n);
    issue(3'b100, 4'd3, 8'h00, 8'hF2, 1'b1);
    cyc();
    chk("ign_q_e1", {24'd0, q}, 32'hCB);
    start = 1'b1; sel = 3'b000; amt = 4'd1; d = 8'hFF;
    cyc();
    start = 1'b0;
    chk("ign_q_e2", {24'd0, q}, 32'hE5);
    wait_done(n);
    chk("ign_q", {24'd0, q}, 32'hF2);
    done_cnt = 0;
    repeat (5) begin
      cyc();
      if (done) done_cnt++;
    end
    chk("ign_extra_done", done_cnt, 0);

    // reset mid-operation aborts without done
    issue(3'b001, 4'd0, 8'h5A, 8'h5A, 1'b1);
    wait_done(n);
    issue(3'b110, 4'd8, 8'h00, 8'h00, 1'b0);
    cyc(); cyc();
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_q", {24'd0, q}, 32'h00);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sout", {31'd0, sout}, 32'd0);
    done_cnt = 0;
    repeat (12) begin
      cyc();
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);

    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
